// File: rtl/alu_exec_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes,
// branch condition codes and result-entry field widths.
package alu_exec_stage_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_LT = 3'd3;
  localparam logic [2:0] COND_GE = 3'd4;
  localparam logic [2:0] COND_VS = 3'd5;
  localparam logic [2:0] COND_VC = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  localparam int ALU_W = 16;
  localparam int RD_W  = 3;
  localparam int ENT_W = ALU_W + RD_W + 2;

endpackage

// File: rtl/ALU_16.sv
// 16-bit combinational ALU with zero/overflow/negative flags.
// Only ADD and SUB report v and n; other ops clear them.
module ALU_16
  import alu_exec_stage_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  op,
  output logic [15:0] result,
  output logic        z,
  output logic        v,
  output logic        n
);

  logic [15:0] sum;
  logic [15:0] dif;

  assign sum = a + b;
  assign dif = a - b;

  always_comb begin
    result = '0;
    v      = 1'b0;
    n      = 1'b0;
    unique case (op)
      ALU_ADD: begin
        result = sum;
        v = (a[15] == b[15]) && (sum[15] != a[15]);
        n = sum[15];
      end
      ALU_SUB: begin
        result = dif;
        v = (a[15] != b[15]) && (dif[15] != a[15]);
        n = dif[15];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: result = {a[14:0], 1'b0};
      ALU_SHR: result = {1'b0, a[15:1]};
    endcase
  end

  assign z = (result == 16'h0000);

endmodule

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main drives the
// output, skid absorbs one op while main is back-pressured.
module alu_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          main_v;
  logic          skid_v;
  logic [DW-1:0] main_d;
  logic [DW-1:0] skid_d;
  logic          acc;
  logic          drain;

  assign in_ready  = !skid_v;
  assign acc       = in_valid && in_ready;
  assign drain     = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (drain) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end else if (acc) begin
      if (!main_v || drain) begin
        main_d <= in_data;
        main_v <= 1'b1;
      end else begin
        skid_d <= in_data;
        skid_v <= 1'b1;
      end
    end else if (drain) begin
      main_v <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: ALU_16, condition-code register,
// branch resolution and a 2-entry skid buffer to writeback.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int W  = ALU_W,
  parameter int RW = RD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  input  logic          in_setf,
  input  logic          in_br,
  input  logic [2:0]    in_cond,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic          out_taken,
  output logic          ccr_z,
  output logic          ccr_v,
  output logic          ccr_n
);

  localparam int PW = W + RW + 2;

  logic [W-1:0]  alu_res;
  logic          alu_z;
  logic          alu_v;
  logic          alu_n;
  logic          cond_ok;
  logic          acc;
  logic          taken;
  logic          we;
  logic [PW-1:0] pay_in;
  logic [PW-1:0] pay_out;

  ALU_16 u_alu (
    .a      (in_a),
    .b      (in_b),
    .op     (in_op),
    .result (alu_res),
    .z      (alu_z),
    .v      (alu_v),
    .n      (alu_n)
  );

  // Branches see the CCR as left by every earlier accepted op.
  always_comb begin
    cond_ok = 1'b0;
    unique case (in_cond)
      COND_AL: cond_ok = 1'b1;
      COND_EQ: cond_ok = ccr_z;
      COND_NE: cond_ok = !ccr_z;
      COND_LT: cond_ok = ccr_n ^ ccr_v;
      COND_GE: cond_ok = !(ccr_n ^ ccr_v);
      COND_VS: cond_ok = ccr_v;
      COND_VC: cond_ok = !ccr_v;
      COND_NV: cond_ok = 1'b0;
    endcase
  end

  assign acc    = in_valid && in_ready && !flush;
  assign taken  = in_br && cond_ok;
  assign we     = in_we && !in_br;
  assign pay_in = {alu_res, in_rd, we, taken};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr_z <= 1'b0;
      ccr_v <= 1'b0;
      ccr_n <= 1'b0;
    end else if (acc && in_setf && !in_br) begin
      ccr_z <= alu_z;
      ccr_v <= alu_v;
      ccr_n <= alu_n;
    end
  end

  alu_skid_buf #(
    .DW (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_result, out_rd, out_we, out_taken} = pay_out;

endmodule
